// File: rtl/async_width_conv_fifo.sv
// 64-bit in / 16-bit out width-converting FIFO on a single clock.
// Define RD_OUTPUT_REG_EN for an extra rd_data pipeline stage (latency 2).
module async_width_conv_fifo #(
    parameter int WR_DEPTH_WIDTH   = 10,
    parameter int WR_DATA_WIDTH    = 64,
    parameter int RD_DEPTH_WIDTH   = 12,
    parameter int RD_DATA_WIDTH    = 16,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                      clk,
    input  logic                      tb_rst,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    input  logic                      rd_en,
    output logic                      rd_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      almost_empty
);

    localparam int LW    = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
    localparam int DEPTH = 1 << WR_DEPTH_WIDTH;
    localparam int SH    = $clog2(RD_DATA_WIDTH);

    localparam logic [WR_DEPTH_WIDTH:0] WR_MAX =
        {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
    localparam logic [RD_DEPTH_WIDTH:0] LANES =
        {{WR_DEPTH_WIDTH{1'b0}}, 1'b1, {LW{1'b0}}};
    localparam logic [WR_DEPTH_WIDTH:0] AF_LVL =
        ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
    localparam logic [RD_DEPTH_WIDTH:0] AE_LVL =
        ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];

    logic [WR_DATA_WIDTH-1:0]  mem [DEPTH];
    logic [WR_DEPTH_WIDTH-1:0] wr_ptr;
    logic [WR_DEPTH_WIDTH-1:0] rd_ptr;
    logic [LW-1:0]             rd_lane;
    logic [RD_DATA_WIDTH-1:0]  rd_q;
    logic [WR_DATA_WIDTH-1:0]  rd_slot;
    logic [RD_DATA_WIDTH-1:0]  rd_word;
    logic [WR_DEPTH_WIDTH:0]   wr_lvl_nxt;
    logic [RD_DEPTH_WIDTH:0]   rd_lvl_nxt;
    logic                      wr_acc;
    logic                      rd_acc;
    logic                      slot_free;

    assign wr_full      = (wr_water_level == WR_MAX);
    assign almost_full  = (wr_water_level >= AF_LVL);
    assign rd_empty     = (rd_water_level == '0);
    assign almost_empty = (rd_water_level <= AE_LVL);

    assign wr_acc    = wr_en & ~wr_full;
    assign rd_acc    = rd_en & ~rd_empty;
    assign slot_free = rd_acc & (&rd_lane);

    assign rd_slot = mem[rd_ptr];
    assign rd_word =
        RD_DATA_WIDTH'(rd_slot >> {rd_lane, {SH{1'b0}}});

    always_comb begin
        wr_lvl_nxt = wr_water_level;
        rd_lvl_nxt = rd_water_level;
        if (wr_acc) begin
            wr_lvl_nxt = wr_lvl_nxt + (WR_DEPTH_WIDTH+1)'(1);
            rd_lvl_nxt = rd_lvl_nxt + LANES;
        end
        if (rd_acc) begin
            rd_lvl_nxt = rd_lvl_nxt - (RD_DEPTH_WIDTH+1)'(1);
        end
        // a slot stays counted until its last lane has been read
        if (slot_free) begin
            wr_lvl_nxt = wr_lvl_nxt - (WR_DEPTH_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rd_lane        <= '0;
            rd_q           <= '0;
            wr_water_level <= '0;
            rd_water_level <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + WR_DEPTH_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_q    <= rd_word;
                rd_lane <= rd_lane + LW'(1);
                if (&rd_lane) begin
                    rd_ptr <= rd_ptr + WR_DEPTH_WIDTH'(1);
                end
            end
            wr_water_level <= wr_lvl_nxt;
            rd_water_level <= rd_lvl_nxt;
        end
    end

`ifdef RD_OUTPUT_REG_EN
    logic                     rd_vld;
    logic [RD_DATA_WIDTH-1:0] rd_q2;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_vld <= 1'b0;
            rd_q2  <= '0;
        end else begin
            rd_vld <= rd_acc;
            if (rd_vld) begin
                rd_q2 <= rd_q;
            end
        end
    end

    assign rd_data = rd_q2;
`else
    assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_async_width_conv_fifo.sv
// Scoreboard bench for async_width_conv_fifo: lane-queue reference model,
// driver pushes expected lanes, monitor pops and compares each cycle.
module tb_async_width_conv_fifo;

`ifdef RD_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        tb_rst;
    logic [63:0] wr_data;
    logic        wr_en;
    logic        wr_full;
    logic [10:0] wr_water_level;
    logic        almost_full;
    logic [15:0] rd_data;
    logic        rd_en;
    logic        rd_empty;
    logic [12:0] rd_water_level;
    logic        almost_empty;

    async_width_conv_fifo dut (
        .clk            (clk),
        .tb_rst         (tb_rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    typedef struct {
        logic [15:0] d;
        int          due;
    } exp_t;

    logic [15:0] lanes [$];
    exp_t        exp_q [$];
    logic [15:0] last_d;
    int          cyc;
    int          checks;
    int          errors;
    bit          mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Occupied write slots: only the head slot may be partially read.
    function automatic int model_wl();
        return (lanes.size() + 3) / 4;
    endfunction

    task automatic drive(input  logic        we,
                         input  logic [63:0] wd,
                         input  logic        re,
                         output bit          wacc);
        bit   racc;
        exp_t e;
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        wacc = we && (model_wl() < 1024);
        racc = re && (lanes.size() > 0);
        if (racc) begin
            e.d   = lanes.pop_front();
            e.due = cyc + LAT;
            exp_q.push_back(e);
        end
        if (wacc) begin
            for (int k = 0; k < 4; k++) lanes.push_back(wd[16*k +: 16]);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 1'b0, a);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        tb_rst = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        lanes.delete();
        exp_q.delete();
        last_d = '0;
        #1;
        chk("rst_wr_lvl", wr_water_level, 0);
        chk("rst_rd_lvl", rd_water_level, 0);
        chk("rst_empty", rd_empty, 1);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk);
        tb_rst = 1'b0;
    endtask

    initial begin
        int   rl;
        int   wl;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                rl = lanes.size();
                wl = model_wl();
                chk("rd_lvl", rd_water_level, rl);
                chk("wr_lvl", wr_water_level, wl);
                chk("wr_full", wr_full, wl == 1024);
                chk("almost_full", almost_full, wl >= 1020);
                chk("rd_empty", rd_empty, rl == 0);
                chk("almost_empty", almost_empty, rl <= 4);
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    e = exp_q.pop_front();
                    chk("rd_due", e.due, cyc);
                end
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    last_d = e.d;
                    chk("rd_data", rd_data, e.d);
                end else begin
                    chk("rd_hold", rd_data, last_d);
                end
            end
        end
    end

    initial begin
        bit          a;
        logic [63:0] d;
        int          pw;
        int          pr;
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        mon_en  = 1'b0;
        last_d  = '0;
        tb_rst  = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        repeat (2) @(negedge clk);
        tb_rst = 1'b0;
        #1;
        chk("init_wr_lvl", wr_water_level, 0);
        chk("init_rd_lvl", rd_water_level, 0);
        chk("init_empty", rd_empty, 1);
        chk("init_aempty", almost_empty, 1);
        chk("init_full", wr_full, 0);
        chk("init_afull", almost_full, 0);
        chk("init_rd_data", rd_data, 0);
        mon_en = 1'b1;
        idle(3);

        d = '1;
        for (int i = 0; i < 1025; i++) begin
            drive(1'b1, d, 1'b0, a);
            if (a) d = d - 64'd1;
        end
        idle(1);
        settle();
        chk("fill_full", wr_full, 1);
        chk("fill_wr_lvl", wr_water_level, 1024);
        chk("fill_rd_lvl", rd_water_level, 4096);

        for (int i = 0; i < 4097; i++) drive(1'b0, 64'd0, 1'b1, a);
        idle(3);
        settle();
        chk("drain_empty", rd_empty, 1);

        drive(1'b1, 64'h4444_3333_2222_1111, 1'b0, a);
        for (int i = 0; i < 4; i++) drive(1'b0, 64'd0, 1'b1, a);
        idle(3);

        drive(1'b1, {$urandom, $urandom}, 1'b0, a);
        drive(1'b1, {$urandom, $urandom}, 1'b0, a);
        drive(1'b1, {$urandom, $urandom}, 1'b1, a);
        idle(1);
        settle();
        chk("sim_rd_lvl", rd_water_level, 11);
        chk("sim_wr_lvl", wr_water_level, 3);
        for (int i = 0; i < 12; i++) drive(1'b0, 64'd0, 1'b1, a);
        idle(3);

        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 2 == 0) ? 70 : 20;
            pr = (ph % 2 == 0) ? 60 : 90;
            for (int i = 0; i < 600; i++) begin
                drive($urandom_range(0, 99) < pw,
                      {$urandom, $urandom},
                      $urandom_range(0, 99) < pr, a);
            end
        end
        idle(3);

        for (int i = 0; i < 512; i++) drive(1'b1, {$urandom, $urandom}, 1'b0, a);
        do_reset();
        drive(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, a);
        drive(1'b0, 64'd0, 1'b1, a);
        idle(3);
        settle();
        chk("post_rst_lane0", rd_data, 16'hCDEF);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
